// File: rtl/mem_access_unit.sv
// Memory access sequencer: turns CPU fetch/load/store phases into single timed
// accesses on a synchronous RAM and holds the CPU until each access completes.
module mem_access_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int WAIT   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        phase,
    input  logic [DATA_W-1:0] IRData,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] DR,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memWriteData,
    output logic              memWren,
    input  logic [DATA_W-1:0] memQ,
    output logic [DATA_W-1:0] memoryData,
    output logic              stall,
    output logic              done,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int         CNT_W    = 4;
    localparam logic [3:0] LAST_CNT = CNT_W'(WAIT - 1);

    localparam logic [4:0] PH_FETCH = 5'b00001;
    localparam logic [4:0] PH_MEM   = 5'b01000;

    logic [1:0]        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              served_q;
    logic [4:0]        phase_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              store_q;

    logic [1:0] opcode;
    logic       is_fetch;
    logic       is_load;
    logic       is_store;
    logic       req;
    logic       phase_changed;
    logic       served_eff;
    logic       start;
    logic       last_access;
    logic       unused_ir;

    assign opcode    = IRData[DATA_W-1:DATA_W-2];
    assign unused_ir = ^IRData[DATA_W-3:0];

    assign is_fetch = (phase == PH_FETCH);
    assign is_load  = (phase == PH_MEM) && (opcode == 2'b00);
    assign is_store = (phase == PH_MEM) && (opcode == 2'b01);
    assign req      = is_fetch || is_load || is_store;

    // A phase change retires the served flag in the same cycle, so a new
    // phase instance can start an access without waiting an extra cycle.
    assign phase_changed = (phase != phase_q);
    assign served_eff    = served_q && !phase_changed;

    assign start       = (state == IDLE) && req && !served_eff;
    assign last_access = (state == ACCESS) && (wait_cnt == LAST_CNT);

    // Handshake: a decoded request asks for an access; stall holds the CPU
    // from the decode cycle through the last ACCESS cycle, and done pulses
    // for one cycle when memoryData carries the fetched or loaded word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            served_q   <= 1'b0;
            phase_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            store_q    <= 1'b0;
            memoryData <= '0;
        end else begin
            phase_q  <= phase;
            served_q <= phase_changed ? 1'b0 : (served_q || last_access);
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCESS;
                        wait_cnt <= '0;
                        addr_q   <= is_fetch ? PC : DR;
                        wdata_q  <= writeData;
                        store_q  <= is_store;
                    end
                end
                ACCESS: begin
                    if (last_access) begin
                        state    <= DONE;
                        wait_cnt <= '0;
                        if (!store_q) begin
                            memoryData <= memQ;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write enable only in the first ACCESS cycle: one RAM write per store.
    assign memAddress   = (state == ACCESS) ? addr_q : '0;
    assign memWriteData = ((state == ACCESS) && store_q) ? wdata_q : '0;
    assign memWren      = (state == ACCESS) && store_q && (wait_cnt == '0);
    assign stall        = (state == ACCESS) || start;
    assign done         = (state == DONE);
    assign fsm_state    = state;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 16, data width, including IRData, writeData, memWriteData, memQ and memoryData.
REQ-002 Parameter ADDR_W, default 16, address width, including PC, DR and memAddress.
REQ-003 Parameter WAIT, default 1, memory read latency in cycles; legal range 1..15.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 phase  in  5  one-hot CPU phase; 5'b00001 = fetch, 5'b01000 = memory phase.
REQ-007 IRData  in  DATA_W  instruction; opcode is IRData[DATA_W-1:DATA_W-2] (00 = load, 01 = store).
REQ-008 writeData  in  DATA_W  store data.
REQ-009 PC  in  ADDR_W  fetch address.
REQ-010 DR  in  ADDR_W  load/store address.
REQ-011 memAddress  out  ADDR_W  address to the synchronous RAM.
REQ-012 memWriteData  out  DATA_W  write data to the RAM.
REQ-013 memWren  out  1  RAM write enable.
REQ-014 memQ  in  DATA_W  RAM read data, valid WAIT cycles after the address is presented.
REQ-015 memoryData  out  DATA_W  registered result of the last fetch or load.
REQ-016 stall  out  1  CPU shall hold its phase while stall is high.
REQ-017 done  out  1  one-cycle pulse marking access completion.

Function
REQ-018 Request decode shall be:
- fetch when phase == 5'b00001;
- load when phase == 5'b01000 and opcode == 00;
- store when phase == 5'b01000 and opcode == 01;
- no request for any other phase or opcode.
REQ-019 The FSM shall have exactly three states: IDLE, ACCESS, DONE.
REQ-020 IDLE -> ACCESS shall occur when a request is decoded and the served flag is 0; on this transition the unit latches the address (PC for fetch, DR otherwise), writeData and the access kind.
REQ-021 ACCESS shall last exactly WAIT cycles, timed by a wait counter, then go to DONE; DONE shall last one cycle, then go to IDLE.
REQ-022 During ACCESS:
- memAddress shall equal the latched address;
- memWriteData shall equal the latched data for a store, 0 otherwise;
- in IDLE and DONE, memAddress and memWriteData shall be 0.
REQ-023 memWren shall be 1 only in the first ACCESS cycle of a store, giving exactly one write per store.
REQ-024 For fetch/load, memoryData shall load memQ at the end of the last ACCESS cycle; a store shall leave memoryData unchanged.
REQ-025 stall shall be 1 in ACCESS, and 1 combinationally in IDLE whenever an unserved request is decoded; it shall be 0 in DONE and otherwise.
REQ-026 done shall be 1 exactly in DONE.
REQ-027 Served flag:
- set on entering DONE;
- cleared on any cycle where phase differs from its value registered on the previous cycle;
- the same phase instance shall never trigger a second access.
REQ-028 Timing: a request decoded in IDLE at cycle t shall give ACCESS at t+1..t+WAIT, and done plus updated memoryData at t+WAIT+1.
REQ-029 Changes to phase, IRData, PC, DR or writeData during ACCESS/DONE shall not affect the in-flight access.
REQ-030 A phase change arriving on the DONE cycle shall clear the served flag, so a new request may start from the following IDLE cycle.
REQ-031 Memory phase with opcode 10 or 11 shall cause no access, no stall and no done.

Reset
REQ-032 While reset is 1 at a rising edge, the unit shall set:
- state = IDLE, wait counter = 0, served flag = 0, registered phase = 0;
- memoryData = 0, memWren = 0, memAddress = 0, memWriteData = 0, done = 0.
REQ-033 Reset during ACCESS shall abort the access, with no further write and no memoryData update.
REQ-034 Reset shall have priority over every other event in the same cycle.

Verification
REQ-035 WAIT=2, phase=00001, PC=0x0010, memQ=0xABCD -> ACCESS for 2 cycles with memAddress=0x0010, done at t+3, memoryData=0xABCD, stall low at t+3.
REQ-036 WAIT=1, phase=01000, IRData=0x4000, DR=0x0022, writeData=0x1234 -> memWren=1 for exactly one cycle with memAddress=0x0022 and memWriteData=0x1234; memoryData unchanged.
REQ-037 phase held at 01000 with a load for 10 cycles after done -> exactly one access, stall stays 0 after DONE.
REQ-038 phase=01000, IRData=0x8000 -> stall=0, memWren=0, done=0, memAddress=0 throughout.
REQ-039 WAIT=3, reset asserted in the second ACCESS cycle of a store -> next cycle memWren=0, memoryData=0, state IDLE, no done pulse.
REQ-040 DR changed from 0x0030 to 0x0040 mid-ACCESS of a load -> memAddress stays 0x0030 until DONE.
